sha256_msg_schedule: RTL and testbench

- Message-schedule stage of the SHA-256 core, sitting directly downstream of the round counter/control block.
- Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready handshake.
- Once started, emits one schedule word W_t per round advance, t = 0..ROUNDS-1, for the compression datapath.
- Uses a 16-word sliding window and expands W_16..W_63 in place.

---
 rtl/sha256_msg_schedule.sv | 93 +++++++++
 tb/tb_sha256_msg_schedule.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule, 16-word sliding window expanding W_16..W_{ROUNDS-1} in place.
// Optional `SHA256_SCHED_ROUND_CHECK_EN adds a sticky sched_err when round_idx disagrees with t.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [31:0]      msg_word,
  input  logic             start,
  input  logic             round_en,
  input  logic [IDX_W-1:0] round_idx,
  output logic [31:0]      w_out,
  output logic [IDX_W-1:0] w_t,
  output logic             w_valid,
  output logic             busy,
  output logic             done
`ifdef SHA256_SCHED_ROUND_CHECK_EN
  ,
  output logic             sched_err
`endif
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, LOADED = 3'd2, RUN = 3'd3, DONE = 3'd4;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);
  logic [2:0] state;
  logic [31:0] win [16];
  logic [3:0] cnt;
  logic [IDX_W-1:0] t;
  logic accept, adv;
  logic [31:0] s0, s1, w_new;
  assign s0 = {win[1][6:0], win[1][31:7]} ^ {win[1][17:0], win[1][31:18]} ^ (win[1] >> 3);
  assign s1 = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
  assign w_new = s1 + win[9] + s0 + win[0];
  // Outputs read zero while reset is held, even though IDLE would otherwise accept words.
  assign msg_ready = reset_n && (state == IDLE || state == LOAD);
  assign accept = msg_valid && msg_ready;
  assign adv = state == RUN && round_en;
  assign w_valid = state == RUN;
  assign busy = state == LOAD || state == LOADED || state == RUN;
  assign done = state == DONE;
  assign w_out = w_valid ? win[0] : '0;
  assign w_t = t;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      t <= '0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt <= '0;
      t <= '0;
    end else begin
      // cnt wraps back to 0 after word 15, so IDLE always writes window[0].
      if (accept) begin
        win[cnt] <= msg_word;
        cnt <= cnt + 4'd1;
      end
      if (adv) begin
        for (int k = 0; k < 15; k++) win[k] <= win[k+1];
        win[15] <= w_new;
        t <= t + 1'b1;
      end
      case (state)
        IDLE:    if (accept) state <= LOAD;
        LOAD:    if (accept && cnt == 4'd15) state <= LOADED;
        LOADED:  if (start) begin
          state <= RUN;
          t <= '0;
        end
        RUN:     if (round_en && t == LAST) state <= DONE;
        DONE:    begin
          state <= IDLE;
          t <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SHA256_SCHED_ROUND_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sched_err <= 1'b0;
    else if (abort) sched_err <= 1'b0;
    else if (adv && round_idx != t) sched_err <= 1'b1;
  end
`else
  logic unused_round_idx;
  assign unused_round_idx = ^round_idx;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized bench checking the schedule against a plain-arithmetic SHA-256 W model.
module tb_sha256_msg_schedule;
  localparam int ROUNDS = 64;
  localparam int IDX_W = 6;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort = 1'b0, msg_valid = 1'b0, start = 1'b0, round_en = 1'b0;
  logic [31:0] msg_word = '0;
  logic [IDX_W-1:0] round_idx = '0;
  logic msg_ready, w_valid, busy, done;
  logic [31:0] w_out;
  logic [IDX_W-1:0] w_t;
`ifdef SHA256_SCHED_ROUND_CHECK_EN
  logic sched_err;
`endif
  sha256_msg_schedule #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_word(msg_word), .start(start), .round_en(round_en), .round_idx(round_idx),
    .w_out(w_out), .w_t(w_t), .w_valid(w_valid), .busy(busy), .done(done)
`ifdef SHA256_SCHED_ROUND_CHECK_EN
    , .sched_err(sched_err)
`endif
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_total = 0;
  logic [31:0] blk [16];
  logic [31:0] wm [64];
  bit mon = 0;
  bit exp_ready = 0, exp_busy = 0, exp_valid = 0, exp_done = 0, exp_err = 0;
  int exp_t = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic set_block(input bit abc);
    for (int i = 0; i < 16; i++)
      blk[i] = abc ? (i == 0 ? 32'h61626380 : i == 15 ? 32'h00000018 : 32'h0) : $urandom;
    for (int i = 0; i < 64; i++)
      if (i < 16) wm[i] = blk[i];
      else wm[i] = (rotr(wm[i-2], 17) ^ rotr(wm[i-2], 19) ^ (wm[i-2] >> 10)) + wm[i-7]
                 + (rotr(wm[i-15], 7) ^ rotr(wm[i-15], 18) ^ (wm[i-15] >> 3)) + wm[i-16];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_idle();
    exp_ready = 1; exp_busy = 0; exp_valid = 0; exp_done = 0; exp_t = 0;
  endtask
  always @(negedge clk) if (mon) begin
    chk("msg_ready", 32'(msg_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("w_valid", 32'(w_valid), 32'(exp_valid));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_valid) begin
      chk("w_out", w_out, wm[exp_t]);
      chk("w_t", 32'(w_t), 32'(exp_t));
    end
`ifdef SHA256_SCHED_ROUND_CHECK_EN
    chk("sched_err", 32'(sched_err), 32'(exp_err));
`endif
  end
  // Loads the first n words of blk; stray start/round_en pulses must be ignored.
  task automatic load_block(input bit toggle, input int n);
    for (int i = 0; i < n; i++) begin
      msg_valid = 1; msg_word = blk[i];
      start = 1'($urandom_range(0, 1)); round_en = 1'($urandom_range(0, 1));
      tick();
      exp_busy = 1; exp_ready = (i < 15);
      if (toggle && i < 15) begin
        msg_valid = 0; msg_word = $urandom;
        tick();
      end
    end
    start = 0; round_en = 0;
    if (n == 16) begin
      msg_valid = 1; msg_word = $urandom; round_en = 1;
      tick();
      tick();
    end
    msg_valid = 0; round_en = 0;
  endtask
  task automatic run_block(input int stall_at, input int abort_at, input bit rnd_en, input int err_at);
    int stall = 0;
    start = 1; round_en = 1'($urandom_range(0, 1)); msg_valid = 1'($urandom_range(0, 1));
    tick();
    start = 0; msg_valid = 0;
    exp_valid = 1; exp_ready = 0; exp_busy = 1; exp_t = 0;
    for (int n = 0; n < 2000 && exp_valid; n++) begin
      if (exp_t == abort_at) begin
        abort = 1; round_en = 1;
        tick();
        abort = 0; round_en = 0; exp_err = 0;
        set_idle();
        return;
      end
      if (exp_t == stall_at && stall < 5) begin
        round_en = 0; stall++;
      end else round_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      round_idx = IDX_W'(exp_t == err_at ? exp_t + 1 : exp_t);
      start = 1'($urandom_range(0, 1));
      msg_valid = 1'($urandom_range(0, 1));
      tick();
      if (round_en) begin
        if (exp_t == err_at) exp_err = 1;
        if (exp_t == ROUNDS - 1) begin
          exp_valid = 0; exp_done = 1; exp_busy = 0;
        end else exp_t++;
      end
    end
    if (exp_valid) chk("run_timeout", 32'(exp_valid), 32'h0);
    start = 0; round_en = 0; msg_valid = 1; msg_word = $urandom;
    tick();
    msg_valid = 0;
    set_idle();
  endtask
  initial begin
    #3;
    chk("rst_msg_ready", 32'(msg_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_w_valid", 32'(w_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_w_out", w_out, 32'h0);
    chk("rst_w_t", 32'(w_t), 32'h0);
    tick();
    tick();
    reset_n = 1;
    set_idle();
    mon = 1;
    set_block(1);
    chk("model_W0", wm[0], 32'h61626380);
    chk("model_W15", wm[15], 32'h00000018);
    chk("model_W16", wm[16], 32'h61626380);
    chk("model_W17", wm[17], 32'h000F0000);
    load_block(0, 16);
    run_block(-1, -1, 0, -1);
    load_block(1, 16);
    run_block(20, -1, 0, -1);
    load_block(0, 16);
    run_block(-1, 30, 0, -1);
    load_block(0, 16);
    run_block(-1, -1, 0, -1);
    set_block(0);
    load_block(1, 7);
    mon = 0;
    reset_n = 0;
    #1;
    chk("midrst_msg_ready", 32'(msg_ready), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_w_valid", 32'(w_valid), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_w_out", w_out, 32'h0);
    chk("midrst_w_t", 32'(w_t), 32'h0);
    tick();
    tick();
    reset_n = 1;
    exp_err = 0;
    set_idle();
    mon = 1;
    set_block(0);
    load_block(1, 16);
    run_block(-1, -1, 1, -1);
    for (int r = 0; r < 4; r++) begin
      set_block(0);
      load_block(1'($urandom_range(0, 1)), 16);
      run_block(int'($urandom_range(0, 63)), r == 2 ? int'($urandom_range(0, 63)) : -1, 1, -1);
    end
`ifdef SHA256_SCHED_ROUND_CHECK_EN
    set_block(1);
    load_block(0, 16);
    run_block(-1, 40, 0, 10);
`endif
    tick();
    mon = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
